// File: rtl/jnt_step_gen_pkg.sv
// Shared constants and state encoding for the joint step generator.
// The INIT_ANGLE values are the FK stage's initial joint angles reduced mod 2^32,
// so both stages restart from the same pose after reset.
package jnt_step_gen_pkg;

  localparam int ANGLE_W = 32;
  localparam int NUM_JNT = 3;

  localparam logic [ANGLE_W-1:0] MAX_STEP_DEF    = 32'd16777216;  // 1/256 rev
  localparam logic [ANGLE_W-1:0] INIT_ANGLE0_DEF = 32'd0;
  localparam logic [ANGLE_W-1:0] INIT_ANGLE1_DEF = 32'd112855247;
  localparam logic [ANGLE_W-1:0] INIT_ANGLE2_DEF = 32'd3582936969;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/jnt_step_gen_calc.sv
// One joint: shortest-path wrap difference between target and current angle,
// clamped to +/-MAX_STEP. Purely combinational.
module jnt_step_calc
  import jnt_step_gen_pkg::*;
#(
  parameter logic [ANGLE_W-1:0] MAX_STEP = MAX_STEP_DEF
) (
  input  logic [ANGLE_W-1:0] tgt,
  input  logic [ANGLE_W-1:0] cur,
  output logic [ANGLE_W-1:0] step,
  output logic               is_zero
);

  logic [ANGLE_W-1:0]        diff;
  logic signed [ANGLE_W:0]   diff_s;
  logic signed [ANGLE_W:0]   pos_lim;
  logic signed [ANGLE_W:0]   neg_lim;

  // Wrap-diff read as signed (0x80000000 is the negative tie), then clamp in
  // 33 bits so -2^31 compares correctly against -MAX_STEP.
  always_comb begin
    diff    = tgt - cur;
    diff_s  = {diff[ANGLE_W-1], diff};
    pos_lim = {1'b0, MAX_STEP};
    neg_lim = -pos_lim;
    step    = diff;
    if (diff_s > pos_lim) begin
      step = MAX_STEP;
    end else if (diff_s < neg_lim) begin
      step = neg_lim[ANGLE_W-1:0];
    end
    is_zero = (diff == '0);
  end

endmodule

// File: rtl/jnt_step_gen.sv
// Joint step generator: takes absolute joint targets, emits rate-limited
// per-joint increments to the FK stage and tracks the current joint angles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Valid never depends on ready; once step_valid is high, jnt_int_n hold
// stable until the transfer. tgt_ready is high only in IDLE, so a sender
// presenting a target while busy must hold it until accepted.
module jnt_step_gen
  import jnt_step_gen_pkg::*;
#(
  parameter logic [ANGLE_W-1:0] MAX_STEP    = MAX_STEP_DEF,
  parameter logic [ANGLE_W-1:0] INIT_ANGLE0 = INIT_ANGLE0_DEF,
  parameter logic [ANGLE_W-1:0] INIT_ANGLE1 = INIT_ANGLE1_DEF,
  parameter logic [ANGLE_W-1:0] INIT_ANGLE2 = INIT_ANGLE2_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [ANGLE_W-1:0] tgt_angle_0,
  input  logic [ANGLE_W-1:0] tgt_angle_1,
  input  logic [ANGLE_W-1:0] tgt_angle_2,
  output logic               step_valid,
  input  logic               step_ready,
  output logic [ANGLE_W-1:0] jnt_int_0,
  output logic [ANGLE_W-1:0] jnt_int_1,
  output logic [ANGLE_W-1:0] jnt_int_2,
  output logic [ANGLE_W-1:0] cur_angle_0,
  output logic [ANGLE_W-1:0] cur_angle_1,
  output logic [ANGLE_W-1:0] cur_angle_2,
  output logic               busy,
  output logic               move_done,
  output logic [1:0]         dbg_state
);

  localparam logic [ANGLE_W-1:0] INIT_ANGLE [NUM_JNT] =
    '{INIT_ANGLE0, INIT_ANGLE1, INIT_ANGLE2};

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] tgt_q  [NUM_JNT];
  logic [ANGLE_W-1:0] tgt_d  [NUM_JNT];
  logic [ANGLE_W-1:0] cur_q  [NUM_JNT];
  logic [ANGLE_W-1:0] cur_d  [NUM_JNT];
  logic [ANGLE_W-1:0] jnt_q  [NUM_JNT];
  logic [ANGLE_W-1:0] jnt_d  [NUM_JNT];
  logic [ANGLE_W-1:0] tgt_in [NUM_JNT];
  logic [ANGLE_W-1:0] step_w [NUM_JNT];
  logic [NUM_JNT-1:0] zero_w;

  assign tgt_in[0] = tgt_angle_0;
  assign tgt_in[1] = tgt_angle_1;
  assign tgt_in[2] = tgt_angle_2;

  for (genvar g = 0; g < NUM_JNT; g++) begin : g_calc
    jnt_step_calc #(.MAX_STEP(MAX_STEP)) u_calc (
      .tgt     (tgt_q[g]),
      .cur     (cur_q[g]),
      .step    (step_w[g]),
      .is_zero (zero_w[g])
    );
  end

  // Next-state logic: latch targets, compute a step, emit it, commit on transfer.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_JNT; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      jnt_d[i] = jnt_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          for (int i = 0; i < NUM_JNT; i++) tgt_d[i] = tgt_in[i];
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Increments are cleared on the way into DONE so they read 0 there.
        if (&zero_w) begin
          for (int i = 0; i < NUM_JNT; i++) jnt_d[i] = '0;
          state_d = ST_DONE;
        end else begin
          for (int i = 0; i < NUM_JNT; i++) jnt_d[i] = step_w[i];
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Current angles move only when the FK stage takes the increment.
        if (step_ready) begin
          for (int i = 0; i < NUM_JNT; i++) cur_d[i] = cur_q[i] + jnt_q[i];
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset restores the FK stage's initial pose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_JNT; i++) begin
        tgt_q[i] <= INIT_ANGLE[i];
        cur_q[i] <= INIT_ANGLE[i];
        jnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_JNT; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
        jnt_q[i] <= jnt_d[i];
      end
    end
  end

  // Status outputs decode straight from the registered state.
  assign tgt_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign step_valid  = (state_q == ST_EMIT);
  assign move_done   = (state_q == ST_DONE);
  assign dbg_state   = state_q;
  assign jnt_int_0   = jnt_q[0];
  assign jnt_int_1   = jnt_q[1];
  assign jnt_int_2   = jnt_q[2];
  assign cur_angle_0 = cur_q[0];
  assign cur_angle_1 = cur_q[1];
  assign cur_angle_2 = cur_q[2];

endmodule

// File: tb/tb_jnt_step_gen.sv
// Bench for jnt_step_gen: table of directed moves, hand sequences for the
// multi-cycle corners, then random moves against a step-sequence model.
module tb_jnt_step_gen;

  localparam logic [31:0] I0 = 32'd0;
  localparam logic [31:0] I1 = 32'd112855247;
  localparam logic [31:0] I2 = 32'd3582936969;
  localparam longint      MAX_L = 64'sd16777216;

  logic        clk, reset;
  logic        tgt_valid, tgt_ready, step_valid, step_ready, busy, move_done;
  logic [31:0] tgt_angle_0, tgt_angle_1, tgt_angle_2;
  logic [31:0] jnt_int_0, jnt_int_1, jnt_int_2;
  logic [31:0] cur_angle_0, cur_angle_1, cur_angle_2;
  logic [1:0]  dbg_state;

  jnt_step_gen dut (
    .clk(clk), .reset(reset),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_angle_0(tgt_angle_0), .tgt_angle_1(tgt_angle_1), .tgt_angle_2(tgt_angle_2),
    .step_valid(step_valid), .step_ready(step_ready),
    .jnt_int_0(jnt_int_0), .jnt_int_1(jnt_int_1), .jnt_int_2(jnt_int_2),
    .cur_angle_0(cur_angle_0), .cur_angle_1(cur_angle_1), .cur_angle_2(cur_angle_2),
    .busy(busy), .move_done(move_done), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  int          n_chk, n_fail;
  logic [95:0] exp_q[$];
  logic [31:0] m_cur [3];

  typedef struct {
    logic [31:0] t0, t1, t2;
    int          n;
    logic [31:0] f0, f1, f2;
    int          mode;   // 0: always ready, 1: random ready, 2: 5-cycle stall after first step
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Shortest signed path, clamped to +/-MAX, as plain 64-bit arithmetic.
  function automatic logic [31:0] ref_step(input logic [31:0] tgt, input logic [31:0] cur);
    logic [31:0] raw;
    longint      d;
    raw = tgt - cur;
    d = longint'($signed(raw));
    if (d > MAX_L) d = MAX_L;
    else if (d < -MAX_L) d = -MAX_L;
    return d[31:0];
  endfunction

  // Model: the whole list of increment triples that walks m_cur to the target.
  task automatic build_expected(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] c0, c1, c2, s0, s1, s2;
    c0 = m_cur[0]; c1 = m_cur[1]; c2 = m_cur[2];
    exp_q.delete();
    for (int k = 0; k < 200; k++) begin
      s0 = ref_step(t0, c0); s1 = ref_step(t1, c1); s2 = ref_step(t2, c2);
      if (s0 == 0 && s1 == 0 && s2 == 0) break;
      exp_q.push_back({s2, s1, s0});
      c0 += s0; c1 += s1; c2 += s2;
    end
  endtask

  // Driver + monitor for one full move.
  task automatic do_move(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                         input int mode, output int n_steps, output logic [95:0] first_step);
    logic [95:0] e, prev_jnt;
    int          cyc, first_evt, stall_cnt;
    bit          done, stall_prev;
    build_expected(t0, t1, t2);
    n_steps = 0; first_step = '0; first_evt = -1; stall_cnt = 0;
    done = 0; stall_prev = 0; prev_jnt = '0;
    @(negedge clk);
    chk("tgt_ready_idle", {31'd0, tgt_ready}, 32'd1);
    tgt_valid = 1'b1; tgt_angle_0 = t0; tgt_angle_1 = t1; tgt_angle_2 = t2;
    step_ready = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    cyc = 1;
    for (int w = 0; w < 3000; w++) begin
      if (first_evt < 0 && (step_valid || move_done)) first_evt = cyc;
      if (stall_prev) begin
        chk("stall_valid_held", {31'd0, step_valid}, 32'd1);
        chk("stall_jnt_stable", {jnt_int_2, jnt_int_1, jnt_int_0} == prev_jnt ? 32'd1 : 32'd0, 32'd1);
      end
      chk("cur_angle_0", cur_angle_0, m_cur[0]);
      chk("cur_angle_1", cur_angle_1, m_cur[1]);
      chk("cur_angle_2", cur_angle_2, m_cur[2]);
      if (move_done) begin
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("done_cur_0", cur_angle_0, t0);
        chk("done_cur_1", cur_angle_1, t1);
        chk("done_cur_2", cur_angle_2, t2);
        chk("done_jnt_zero", jnt_int_0 | jnt_int_1 | jnt_int_2, 32'd0);
        done = 1;
        break;
      end
      case (mode)
        1:       step_ready = 1'($urandom_range(0, 1));
        2:       step_ready = !(n_steps == 1 && stall_cnt < 5);
        default: step_ready = 1'b1;
      endcase
      stall_prev = 0;
      if (step_valid) begin
        if (step_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_step", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (n_steps == 0) first_step = {jnt_int_2, jnt_int_1, jnt_int_0};
            chk("step_jnt_0", jnt_int_0, e[31:0]);
            chk("step_jnt_1", jnt_int_1, e[63:32]);
            chk("step_jnt_2", jnt_int_2, e[95:64]);
            m_cur[0] += e[31:0]; m_cur[1] += e[63:32]; m_cur[2] += e[95:64];
          end
          n_steps++;
        end else begin
          stall_prev = 1;
          stall_cnt++;
          prev_jnt = {jnt_int_2, jnt_int_1, jnt_int_0};
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("move_timeout", 32'd0, 32'd1);
    chk("first_event_latency", first_evt, 32'd2);
    if (mode == 2) chk("stall_cycles", stall_cnt, 32'd5);
    step_ready = 1'b1;
  endtask

  initial begin
    int          n;
    logic [95:0] f;
    logic [31:0] r0, r1, r2;

    vecs[0] = '{t0: 32'd50000000, t1: I1, t2: I2, n: 3,
                f0: 32'd16777216, f1: 32'd0, f2: 32'd0, mode: 0};
    vecs[1] = '{t0: 32'd0, t1: I1, t2: I2, n: 3,
                f0: 32'hFF000000, f1: 32'd0, f2: 32'd0, mode: 2};
    vecs[2] = '{t0: 32'hFFFF0000, t1: I1, t2: I2, n: 1,
                f0: 32'hFFFF0000, f1: 32'd0, f2: 32'd0, mode: 0};
    vecs[3] = '{t0: 32'd0, t1: I1, t2: I2, n: 1,
                f0: 32'h00010000, f1: 32'd0, f2: 32'd0, mode: 1};
    vecs[4] = '{t0: 32'h80000000, t1: I1, t2: I2, n: 128,
                f0: 32'hFF000000, f1: 32'd0, f2: 32'd0, mode: 0};
    vecs[5] = '{t0: 32'h80000000, t1: I1, t2: I2, n: 0,
                f0: 32'd0, f1: 32'd0, f2: 32'd0, mode: 0};
    vecs[6] = '{t0: 32'h80000000, t1: 32'd112855347, t2: 32'd3566159752, n: 2,
                f0: 32'd0, f1: 32'd100, f2: 32'hFF000000, mode: 1};

    n_chk = 0; n_fail = 0;
    reset = 1'b0; tgt_valid = 1'b0; step_ready = 1'b1;
    tgt_angle_0 = '0; tgt_angle_1 = '0; tgt_angle_2 = '0;
    m_cur[0] = I0; m_cur[1] = I1; m_cur[2] = I2;

    // Reset state
    #12;
    chk("rst_tgt_ready", {31'd0, tgt_ready}, 32'd1);
    chk("rst_step_valid", {31'd0, step_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_move_done", {31'd0, move_done}, 32'd0);
    chk("rst_jnt", jnt_int_0 | jnt_int_1 | jnt_int_2, 32'd0);
    chk("rst_cur_0", cur_angle_0, I0);
    chk("rst_cur_1", cur_angle_1, I1);
    chk("rst_cur_2", cur_angle_2, I2);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int v = 0; v < 7; v++) begin
      do_move(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].mode, n, f);
      chk("vec_n_steps", n, vecs[v].n);
      if (vecs[v].n > 0) begin
        chk("vec_first_0", f[31:0], vecs[v].f0);
        chk("vec_first_1", f[63:32], vecs[v].f1);
        chk("vec_first_2", f[95:64], vecs[v].f2);
      end
    end

    // Target equal to current, with a second target offered while busy
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_angle_0 = m_cur[0]; tgt_angle_1 = m_cur[1]; tgt_angle_2 = m_cur[2];
    @(negedge clk);
    tgt_angle_0 = m_cur[0] + 32'd5;
    chk("eq_calc_ready", {31'd0, tgt_ready}, 32'd0);
    chk("eq_calc_busy", {31'd0, busy}, 32'd1);
    chk("eq_calc_done", {31'd0, move_done}, 32'd0);
    chk("eq_calc_valid", {31'd0, step_valid}, 32'd0);
    @(negedge clk);
    chk("eq_done_pulse", {31'd0, move_done}, 32'd1);
    chk("eq_done_valid", {31'd0, step_valid}, 32'd0);
    chk("eq_done_ready", {31'd0, tgt_ready}, 32'd0);
    chk("eq_done_jnt", jnt_int_0 | jnt_int_1 | jnt_int_2, 32'd0);
    @(negedge clk);
    chk("eq_after_done", {31'd0, move_done}, 32'd0);
    chk("eq_after_busy", {31'd0, busy}, 32'd0);
    chk("eq_after_ready", {31'd0, tgt_ready}, 32'd1);
    chk("eq_after_cur_0", cur_angle_0, m_cur[0]);
    tgt_valid = 1'b0;

    // Reset while a step is waiting in EMIT
    @(negedge clk);
    step_ready = 1'b0;
    tgt_valid = 1'b1;
    tgt_angle_0 = m_cur[0] + 32'h40000000; tgt_angle_1 = m_cur[1]; tgt_angle_2 = m_cur[2];
    @(negedge clk);
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("emit_before_rst", {31'd0, step_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, step_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_jnt", jnt_int_0 | jnt_int_1 | jnt_int_2, 32'd0);
    chk("rst_mid_cur_0", cur_angle_0, I0);
    chk("rst_mid_cur_1", cur_angle_1, I1);
    chk("rst_mid_cur_2", cur_angle_2, I2);
    @(negedge clk);
    reset = 1'b1;
    step_ready = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", {31'd0, tgt_ready}, 32'd1);
    chk("rst_rel_valid", {31'd0, step_valid}, 32'd0);
    m_cur[0] = I0; m_cur[1] = I1; m_cur[2] = I2;

    // Random moves
    for (int k = 0; k < 8; k++) begin
      r0 = ($urandom_range(0, 3) == 0) ? m_cur[0] : $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? m_cur[1] : m_cur[1] + $urandom_range(0, 32'h04000000) - 32'h02000000;
      r2 = ($urandom_range(0, 3) == 0) ? m_cur[2] : $urandom;
      do_move(r0, r1, r2, 1, n, f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
